// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches words over req/ack, resolves two-word jumps via the decision unit, issues the rest.
// Optional redirect counter enabled by defining FETCH_SEQ_REDIRECT_COUNT_EN.
module fetch_sequencer #(
  parameter int                   WORD_SIZE    = 16,
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [WORD_SIZE-1:0] program_counter_address,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [WORD_SIZE-1:0] peek_jump_address,
  input  logic [WORD_SIZE-1:0] new_address,
  input  logic                 alu_busy,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [15:0]          redirect_count
);

  typedef enum logic [1:0] {FETCH, PEEK, RESOLVE, ISSUE} state_t;

  localparam logic [WORD_SIZE-1:0] PC_STEP = WORD_SIZE'(1);

  state_t               state, state_next;
  logic [WORD_SIZE-1:0] pc;
  logic [7:0]           opcode;
  logic                 is_jump;
  logic                 resolve_done;

  assign opcode       = mem_rdata[WORD_SIZE-1 -: 8];
  assign is_jump      = (opcode >= 8'h14) && (opcode <= 8'h24);
  assign resolve_done = (state == RESOLVE) && !alu_busy;

  assign mem_addr                = pc;
  assign program_counter_address = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  // mem_req is gated by rst_n so an abandoned request drops the moment reset asserts.
  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    issue_valid = 1'b0;
    case (state)
      FETCH: begin
        mem_req = rst_n;
        if (mem_ack) state_next = is_jump ? PEEK : ISSUE;
      end
      PEEK: begin
        mem_req = rst_n;
        if (mem_ack) state_next = RESOLVE;
      end
      RESOLVE: begin
        if (!alu_busy) state_next = FETCH;
      end
      ISSUE: begin
        issue_valid = 1'b1;
        if (issue_ready) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc                <= RESET_VECTOR;
      instruction       <= '0;
      peek_jump_address <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ack) begin
            instruction <= mem_rdata;
            pc          <= pc + PC_STEP;
          end
        end
        PEEK: begin
          if (mem_ack) begin
            peek_jump_address <= mem_rdata;
            pc                <= pc + PC_STEP;
          end
        end
        RESOLVE: begin
          if (!alu_busy) pc <= new_address;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_SEQ_REDIRECT_COUNT_EN
  logic [15:0] redirect_q;

  // A redirect is any resolved jump whose target is not the fall-through PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_q <= '0;
    end else if (resolve_done && (new_address != pc)) begin
      redirect_q <= redirect_q + 16'd1;
    end
  end

  assign redirect_count = redirect_q;
`else
  assign redirect_count = '0;
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch sequencer that drives the decision unit from the other side. It reads instruction words from program memory over a req/ack port and detects two-word jump instructions (opcodes 0x14–0x24). For a jump it fetches the operand word, presents fall-through PC, opcode and operand to the decision unit, then loads the returned `new_address` into the PC. All other instructions go to the execute stage through a valid/ready handshake.

## Interface
- `WORD_SIZE`, 16: width of PC, memory data, instruction and jump operand.
- `RESET_VECTOR`, 0: PC value after reset.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `mem_req` output 1: memory read request.
- `mem_addr` output WORD_SIZE: read address, equal to current PC.
- `mem_ack` input 1: read data valid this cycle; ignored while `mem_req` is low.
- `mem_rdata` input WORD_SIZE: read data.
- `program_counter_address` output WORD_SIZE: fall-through PC to the decision unit (PC after operand).
- `instruction` output WORD_SIZE: latched instruction word, to the decision unit and execute stage.
- `peek_jump_address` output WORD_SIZE: latched jump operand word.
- `new_address` input WORD_SIZE: decision unit result, sampled only in RESOLVE.
- `alu_busy` input 1: ALU flags not yet final; blocks RESOLVE.
- `issue_valid` output 1: `instruction` valid for the execute stage.
- `issue_ready` input 1: execute stage accepts.
- `redirect_count` output 16: jumps whose target differs from fall-through (see Configuration).

## Operation
- States: FETCH, PEEK, RESOLVE, ISSUE. Reset state is FETCH.
- FETCH: `mem_req`=1, `mem_addr`=PC. On `mem_ack`:
  - `instruction`<=`mem_rdata`.
  - PC<=PC+1.
  - If `mem_rdata[15:8]` is in 0x14..0x24 inclusive, go to PEEK. Otherwise go to ISSUE.
- PEEK: `mem_req`=1, `mem_addr`=PC. On `mem_ack`: `peek_jump_address`<=`mem_rdata`, PC<=PC+1, go to RESOLVE.
- RESOLVE: `mem_req`=0. `program_counter_address`=PC at all times.
  - While `alu_busy`=1, hold.
  - On the first cycle with `alu_busy`=0: PC<=`new_address`, go to FETCH.
  - Jumps are never issued (`issue_valid` stays 0).
- ISSUE: `issue_valid`=1 and `instruction` held stable until the `issue_valid`&&`issue_ready` cycle, then go to FETCH. `issue_valid` never drops without a handshake.
- PC arithmetic is modulo 2^WORD_SIZE: 0xFFFF+1 = 0x0000, including for the operand fetch.
- `mem_req` stays asserted and `mem_addr` stays stable until `mem_ack`. Memory latency is unbounded.
- Reset values, applied asynchronously:
  - PC=`mem_addr`=`program_counter_address`=RESET_VECTOR.
  - `mem_req`=0 while reset is asserted; the first cycle after release is FETCH with `mem_req`=1.
  - `instruction`=0, `peek_jump_address`=0, `issue_valid`=0, `redirect_count`=0.
- Reset mid-transaction: `mem_req` drops immediately and an in-flight ack is discarded. The memory tolerates abandoned requests.

## Timing
- Non-jump, zero-wait memory (ack in the same cycle as req):
  - FETCH takes 1 cycle; `issue_valid` rises the next cycle.
  - With `issue_ready`=1, the next FETCH starts the cycle after that: 2 cycles per instruction.
- Jump, zero-wait memory, `alu_busy`=0: FETCH, PEEK, RESOLVE, then fetch of the target. That is 3 cycles from the opcode request to the target request.
- Each memory wait cycle adds 1 cycle. Each `alu_busy` cycle in RESOLVE adds 1 cycle.
- `new_address` is combinational from the decision unit and must be stable in the RESOLVE cycle where `alu_busy`=0. The decision unit adds no registered latency.

## Configuration
- `FETCH_SEQ_REDIRECT_COUNT_EN` defined:
  - `redirect_count` increments by 1 on each RESOLVE exit where `new_address` != `program_counter_address`.
  - It wraps 0xFFFF to 0x0000.
  - It is reset to 0 by `rst_n`.
- Not defined: the counter logic is absent and `redirect_count` is tied to 0.

## Test plan
- Reset release with RESET_VECTOR=0 → first cycle after release: `mem_req`=1, `mem_addr`=0x0000, `issue_valid`=0.
- 0x0312 at 0x0000, `issue_ready` low 3 cycles → `issue_valid`=1 with `instruction`=0x0312 held for 4 cycles; next request at 0x0001.
- JE 0x1500 at 0x0010, operand 0x0200, decision returns 0x0200:
  - RESOLVE shows `program_counter_address`=0x0012.
  - Next request at 0x0200.
  - No `issue_valid`.
  - `redirect_count`=1 with macro, 0 without.
- JNE 0x1600 at 0x0020, not taken (`new_address`=0x0022) → next request at 0x0022, `redirect_count` unchanged.
- Jump with `alu_busy` high 4 cycles in RESOLVE → PC unchanged and `mem_req`=0 for 4 cycles; target fetched in the cycle after busy drops.
- Wrap and reset: non-jump at 0xFFFF → next request at 0x0000. Separately, `rst_n` low while `mem_req`=1 awaiting ack → `mem_req`=0 immediately, PC=RESET_VECTOR.
